gpio_wb_arbiter: RTL and testbench
==================================

# gpio_wb_arbiter

Two-port Wishbone classic slave front end for the 32-bit GPIO register block (DIR, OUT, IN). It arbitrates round-robin between the CPU data port (m0) and the NoC network-interface port (m1). Each granted access is sequenced onto the GPIO block's single addr/we/wdata/rdata register port. It also provides atomic OUT set/clear/toggle aliases, executed as an internal read-modify-write, so the two masters cannot corrupt each other's pin updates.

## Interface
- DATA_W, 32, data width of the Wishbone and GPIO register paths; must equal the GPIO block width.
- clk  in  1  single clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (CPU) Wishbone cycle, strobe, write enable.
- m0_adr_i  in  3  master 0 word offset.
- m0_dat_i  in  DATA_W  master 0 write data.
- m0_dat_o  out  DATA_W  master 0 read data; valid only while m0_ack_o is high.
- m0_ack_o  out  1  master 0 single-cycle acknowledge.
- m1_*  same set of signals for master 1 (NoC).
- gpio_addr  out  2  GPIO register select.
- gpio_we  out  1  GPIO write strobe.
- gpio_wdata  out  DATA_W  GPIO write data.
- gpio_rdata  in  DATA_W  GPIO read data; combinational from gpio_addr.

## Operation
- Word offset map:
  - 0 = DIR (r/w)
  - 1 = OUT (r/w)
  - 2 = IN (read-only; writes are acked and discarded)
  - 3 = reserved (reads return 0, writes are ignored)
  - 4 = OUT_SET: OUT |= data
  - 5 = OUT_CLR: OUT &= ~data
  - 6 = OUT_TGL: OUT ^= data
  - 7 = reserved (reads return 0, writes are ignored)
- Reads of offsets 4–6 return OUT.
- A request is cyc_i & stb_i. Requests are evaluated only in IDLE.
- Arbitration is round-robin on the register last_grant:
  - If both masters request, the master not in last_grant wins.
  - A lone requester always wins.
  - last_grant resets to 1, so m0 wins the first tie.
  - last_grant updates when the grant is taken.
- FSM states: IDLE, ACCESS, RMW_WR, ACK.
  - IDLE: on any request, latch the winner's grant id, adr, we and dat. Go to ACCESS.
  - ACCESS: drive gpio_addr = adr[1:0] (offsets 4–6 map to 1).
    - gpio_we = 1 only for writes to offset 0 or 1, with gpio_wdata = latched data.
    - Capture gpio_rdata into rd_q (reserved offsets capture 0).
    - For writes to offsets 4–6, go to RMW_WR; otherwise go to ACK.
  - RMW_WR: gpio_addr = 1, gpio_we = 1, gpio_wdata = f(rd_q, data) per the offset map. rd_q takes the new OUT value. Go to ACK.
  - ACK: assert the granted master's ack_o with dat_o = rd_q. Go to IDLE.
- Write-response data:
  - Plain writes return the pre-write register value.
  - RMW writes return the new OUT value.
- The non-granted master's ack_o stays 0, and its dat_o holds 0.
- Abort: if the granted master's cyc_i is low in ACK, ack_o is suppressed. Any GPIO write already issued stands. The FSM still returns to IDLE.
- Masters must drop stb_i in the cycle after ack. If stb_i is still high in IDLE, it is treated as a new request.

## Timing
- Reset (synchronous) drives the following, all effective at the first edge with rst = 1:
  - state = IDLE, last_grant = 1
  - gpio_addr = 0, gpio_we = 0, gpio_wdata = 0
  - both ack_o = 0, both dat_o = 0
- Reset mid-transaction aborts the transaction with no ack. A GPIO write whose edge coincides with rst still lands, because the GPIO block sees the strobe.
- gpio_addr, gpio_we and gpio_wdata are registered. gpio_we is high for exactly one cycle per write phase and is never high in IDLE or ACK.
- Plain access: request sampled at edge E0; ACCESS during E0–E1; GPIO commit and rd_q capture at E1; ack high during E1–E2. Ack follows the sampling edge by 2 cycles.
- RMW access: read at E1, write commit at E2, ack high during E2–E3 (3 cycles).
- Back-to-back: minimum 1 IDLE cycle between transactions. With two continuous requesters, grants alternate strictly.

## Test plan
- After reset, m0 writes 0x0000_00FF to offset 0, then reads offset 0 -> each ack is 2 cycles after the request; the read returns 0x0000_00FF; gpio_we pulses once, with addr 0.
- OUT = 0x0000_F0F0, then m1 writes 0x0000_000F to offset 4 -> gpio_we pulses at addr 1 with wdata 0x0000_F0FF; ack after 3 cycles with dat_o 0x0000_F0FF. Then 0x0000_00F0 to offset 5 -> OUT = 0x0000_F00F. Then 0x0000_FFFF to offset 6 -> OUT = 0x0000_0FF0.
- m0 and m1 both hold continuous read requests -> grants alternate m0, m1, m0, m1; neither master starves.
- m0 writes 0xDEAD_BEEF to offset 2 and then to offset 7 -> both are acked with no gpio_we pulse. A read of offset 7 returns 0.
- m1 drops cyc_i during ACCESS of a write to offset 1 -> OUT updates, m1_ack_o stays 0, and the FSM is back in IDLE after 3 cycles.
- rst asserted during RMW_WR -> next cycle all outputs are 0 and state is IDLE; a subsequent tie is won by m0.

Source files
------------

// File: rtl/gpio_wb_arbiter.sv
// rtl/gpio_wb_arbiter.sv - two-master round-robin Wishbone front end for the GPIO register block
//
// Purpose: arbitrates between m0 (CPU) and m1 (NoC) Wishbone classic slaves and
// sequences each granted access onto the single GPIO register port. Offsets 4-6
// are OUT set/clear/toggle aliases executed as an internal read-modify-write.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i          master N cycle, strobe, write enable
//   mN_adr_i [2:0]               master N word offset
//   mN_dat_i / mN_dat_o          master N write / read data
//   mN_ack_o                     master N single-cycle acknowledge
//   gpio_addr/we/wdata           registered GPIO register-port request
//   gpio_rdata                   GPIO read data, combinational from gpio_addr
module gpio_wb_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [2:0]        m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [2:0]        m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic [1:0]        gpio_addr,
    output logic              gpio_we,
    output logic [DATA_W-1:0] gpio_wdata,
    input  logic [DATA_W-1:0] gpio_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, ACK} state_t;

    state_t            state;
    logic              last_grant;   // 0 = m0, 1 = m1
    logic              gnt;
    logic [2:0]        adr_q;
    logic              we_q;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] rd_q;

    logic              m0_req;
    logic              m1_req;
    logic              win;
    logic [2:0]        req_adr;
    logic              req_we;
    logic [DATA_W-1:0] req_dat;
    logic              reserved;
    logic [DATA_W-1:0] rd_cap;
    logic              rmw;
    logic [DATA_W-1:0] rmw_val;
    logic              enter_ack;
    logic [DATA_W-1:0] ack_val;

    always_comb begin
        m0_req  = m0_cyc_i & m0_stb_i;
        m1_req  = m1_cyc_i & m1_stb_i;
        // On a tie the master that did not win last time gets the grant.
        win     = (m0_req && m1_req) ? ~last_grant : m1_req;
        req_adr = win ? m1_adr_i : m0_adr_i;
        req_we  = win ? m1_we_i  : m0_we_i;
        req_dat = win ? m1_dat_i : m0_dat_i;

        // Offsets 3 and 7 are holes: reads see zero regardless of the GPIO port.
        reserved = (adr_q[1:0] == 2'b11);
        rd_cap   = reserved ? '0 : gpio_rdata;
        rmw      = we_q & adr_q[2] & ~reserved;
        case (adr_q[1:0])
            2'd0:    rmw_val = rd_cap | dat_q;
            2'd1:    rmw_val = rd_cap & ~dat_q;
            default: rmw_val = rd_cap ^ dat_q;
        endcase

        enter_ack = ((state == ACCESS) && !rmw) || (state == RMW_WR);
        ack_val   = (state == RMW_WR) ? rd_q : rd_cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            rd_q       <= '0;
            gpio_addr  <= '0;
            gpio_we    <= 1'b0;
            gpio_wdata <= '0;
            m0_ack_o   <= 1'b0;
            m0_dat_o   <= '0;
            m1_ack_o   <= 1'b0;
            m1_dat_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt        <= win;
                        last_grant <= win;
                        adr_q      <= req_adr;
                        we_q       <= req_we;
                        dat_q      <= req_dat;
                        // Alias offsets read OUT; only DIR/OUT accept direct writes.
                        gpio_addr  <= req_adr[2] ? 2'd1 : req_adr[1:0];
                        gpio_we    <= req_we & ~req_adr[2] & ~req_adr[1];
                        gpio_wdata <= req_dat;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (rmw) begin
                        gpio_addr  <= 2'd1;
                        gpio_we    <= 1'b1;
                        gpio_wdata <= rmw_val;
                        rd_q       <= rmw_val;
                        state      <= RMW_WR;
                    end else begin
                        gpio_we    <= 1'b0;
                        rd_q       <= rd_cap;
                        state      <= ACK;
                    end
                end
                RMW_WR: begin
                    gpio_we <= 1'b0;
                    state   <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Ack is registered on entry to ACK; a master that has dropped cyc_i
            // by then is treated as having aborted and receives nothing.
            m0_ack_o <= enter_ack & ~gnt & m0_cyc_i;
            m0_dat_o <= (enter_ack & ~gnt & m0_cyc_i) ? ack_val : '0;
            m1_ack_o <= enter_ack & gnt & m1_cyc_i;
            m1_dat_o <= (enter_ack & gnt & m1_cyc_i) ? ack_val : '0;
        end
    end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// tb/tb_gpio_wb_arbiter.sv - self-checking bench for gpio_wb_arbiter
module tb_gpio_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [2:0]  m0_adr_i;
    logic [31:0] m0_dat_i, m0_dat_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [2:0]  m1_adr_i;
    logic [31:0] m1_dat_i, m1_dat_o;
    logic        m1_ack_o;
    logic [1:0]  gpio_addr;
    logic        gpio_we;
    logic [31:0] gpio_wdata;
    logic [31:0] gpio_rdata;

    gpio_wb_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .gpio_addr(gpio_addr), .gpio_we(gpio_we), .gpio_wdata(gpio_wdata),
        .gpio_rdata(gpio_rdata)
    );

    always #5 clk = ~clk;

    // GPIO register block stand-in
    logic [31:0] gpio_dir = 32'h0;
    logic [31:0] gpio_out = 32'h0;
    logic [31:0] gpio_in  = 32'h1357_9BDF;

    always_comb begin
        case (gpio_addr)
            2'd0:    gpio_rdata = gpio_dir;
            2'd1:    gpio_rdata = gpio_out;
            2'd2:    gpio_rdata = gpio_in;
            default: gpio_rdata = 32'hBAD0_BAD0;
        endcase
    end

    int          pulses = 0;
    logic [1:0]  last_paddr;
    logic [31:0] last_pwdata;

    always @(posedge clk) begin
        if (gpio_we) begin
            case (gpio_addr)
                2'd0:    gpio_dir <= gpio_wdata;
                2'd1:    gpio_out <= gpio_wdata;
                default: ;
            endcase
            pulses      <= pulses + 1;
            last_paddr  <= gpio_addr;
            last_pwdata <= gpio_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_dir = 32'h0;
    logic [31:0] ref_out = 32'h0;
    int          ref_last = 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [2:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    // One complete single-master transaction checked against the model.
    task automatic xact(input int m, input logic [2:0] adr, input logic we, input logic [31:0] dat);
        logic [31:0] exp_rsp, p_wdata;
        logic [1:0]  p_addr;
        int          exp_lat, exp_p, p0, cnt;
        logic        got_ack;
        exp_rsp = 32'h0; p_wdata = 32'h0; p_addr = 2'd0; exp_lat = 2; exp_p = 0;
        if (!we) begin
            case (adr)
                3'd0:             exp_rsp = ref_dir;
                3'd1, 3'd4, 3'd5, 3'd6: exp_rsp = ref_out;
                3'd2:             exp_rsp = gpio_in;
                default:          exp_rsp = 32'h0;
            endcase
        end else begin
            case (adr)
                3'd0: begin exp_rsp = ref_dir; ref_dir = dat; exp_p = 1; p_addr = 2'd0; p_wdata = dat; end
                3'd1: begin exp_rsp = ref_out; ref_out = dat; exp_p = 1; p_addr = 2'd1; p_wdata = dat; end
                3'd2: exp_rsp = gpio_in;
                3'd4, 3'd5, 3'd6: begin
                    if (adr == 3'd4)      ref_out = ref_out | dat;
                    else if (adr == 3'd5) ref_out = ref_out & ~dat;
                    else                  ref_out = ref_out ^ dat;
                    exp_rsp = ref_out; exp_p = 1; p_addr = 2'd1; p_wdata = ref_out; exp_lat = 3;
                end
                default: exp_rsp = 32'h0;
            endcase
        end
        p0 = pulses;
        @(negedge clk);
        drive(m, 1'b1, 1'b1, we, adr, dat);
        cnt = 0; got_ack = 1'b0;
        while (!got_ack && cnt < 10) begin
            @(negedge clk);
            cnt++;
            got_ack = (m == 0) ? m0_ack_o : m1_ack_o;
        end
        if (!got_ack) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("ack_latency", cnt, exp_lat);
            check("ack_data", (m == 0) ? m0_dat_o : m1_dat_o, exp_rsp);
            check("other_ack", (m == 0) ? {31'd0, m1_ack_o} : {31'd0, m0_ack_o}, 32'd0);
            check("other_dat", (m == 0) ? m1_dat_o : m0_dat_o, 32'd0);
            check("we_in_ack", {31'd0, gpio_we}, 32'd0);
        end
        drive(m, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        check("pulse_count", pulses - p0, exp_p);
        if (exp_p != 0) begin
            check("pulse_addr", {30'd0, last_paddr}, {30'd0, p_addr});
            check("pulse_wdata", last_pwdata, p_wdata);
        end
        check("gpio_out_state", gpio_out, ref_out);
        ref_last = m;
    endtask

    // Both masters hold reads (m0 on DIR, m1 on OUT); grants must alternate.
    task automatic alternate(input int n);
        int   cnt, winner;
        logic hit;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0);
        for (int k = 0; k < n; k++) begin
            cnt = 0; hit = 1'b0;
            while (!hit && cnt < 10) begin
                @(negedge clk);
                cnt++;
                hit = m0_ack_o | m1_ack_o;
            end
            if (!hit) begin
                check("alt_timeout", 32'd0, 32'd1);
                break;
            end
            check("alt_single_ack", {31'd0, m0_ack_o & m1_ack_o}, 32'd0);
            winner = m0_ack_o ? 0 : 1;
            check("alt_winner", winner, 1 - ref_last);
            check("alt_data", (winner == 0) ? m0_dat_o : m1_dat_o, (winner == 0) ? ref_dir : ref_out);
            ref_last = winner;
            if (k == n - 1) begin
                drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
                drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
            end else begin
                drive(winner, 1'b1, 1'b0, 1'b0, (winner == 0) ? 3'd0 : 3'd1, 32'h0);
                @(negedge clk);
                drive(winner, 1'b1, 1'b1, 1'b0, (winner == 0) ? 3'd0 : 3'd1, 32'h0);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d, nv;
        int          p0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_addr", {30'd0, gpio_addr}, 32'd0);
        check("rst_we", {31'd0, gpio_we}, 32'd0);
        check("rst_wdata", gpio_wdata, 32'd0);
        check("rst_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        check("rst_dat", m0_dat_o | m1_dat_o, 32'd0);
        rst = 1'b0;

        // DIR write then read-back
        xact(0, 3'd0, 1'b1, 32'h0000_00FF);
        xact(0, 3'd0, 1'b0, 32'h0);
        check("dir_ff", gpio_dir, 32'h0000_00FF);

        // OUT set / clear / toggle aliases
        xact(0, 3'd1, 1'b1, 32'h0000_F0F0);
        xact(1, 3'd4, 1'b1, 32'h0000_000F);
        check("out_set", gpio_out, 32'h0000_F0FF);
        xact(1, 3'd5, 1'b1, 32'h0000_00F0);
        check("out_clr", gpio_out, 32'h0000_F00F);
        xact(1, 3'd6, 1'b1, 32'h0000_FFFF);
        check("out_tgl", gpio_out, 32'h0000_0FF0);

        // Writes to IN and reserved offsets, reserved read
        xact(0, 3'd2, 1'b1, 32'hDEAD_BEEF);
        xact(0, 3'd7, 1'b1, 32'hDEAD_BEEF);
        xact(0, 3'd7, 1'b0, 32'h0);
        xact(0, 3'd3, 1'b0, 32'h0);

        // Continuous contention
        alternate(6);

        // m1 aborts a write to OUT during ACCESS
        d  = 32'hA5A5_1234;
        p0 = pulses;
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 3'd1, d);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", {31'd0, m1_ack_o}, 32'd0);
        end
        check("abort_out", gpio_out, d);
        check("abort_pulses", pulses - p0, 32'd1);
        ref_out  = d;
        ref_last = 1;
        xact(1, 3'd1, 1'b0, 32'h0);

        // Randomized single-master traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) gpio_in = $urandom;
            xact($urandom_range(0, 1), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Reset during RMW_WR: write lands, outputs clear, m0 wins the next tie
        d  = $urandom;
        nv = ref_out | d;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 3'd4, d);
        @(negedge clk);
        @(negedge clk);
        check("rmw_we_before_rst", {31'd0, gpio_we}, 32'd1);
        check("rmw_wdata_before_rst", gpio_wdata, nv);
        rst = 1'b1;
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
        check("mid_rst_addr", {30'd0, gpio_addr}, 32'd0);
        check("mid_rst_we", {31'd0, gpio_we}, 32'd0);
        check("mid_rst_wdata", gpio_wdata, 32'd0);
        check("mid_rst_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        check("mid_rst_dat", m0_dat_o | m1_dat_o, 32'd0);
        rst = 1'b0;
        check("rst_write_landed", gpio_out, nv);
        ref_out  = nv;
        ref_last = 1;
        alternate(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
